conv1d_stream_layer: RTL and testbench
======================================

// Module: conv1d_stream_layer
// PURPOSE
//  Streaming 1-D convolution layer and the consumer/producer end of the x/y valid-ready
//  protocol used by our net_* blocks. Receives M kernel weights, then N input samples, on x.
//  Computes the N-M+1 outputs y[k] = sum_m w[m]*x[k+m] with an optional ReLU and signed
//  saturation, and transmits them on y. Building block for the conv stages inside net_* tops.
// PARAMETERS
//  T     16  data width (signed two's complement) of x_data, y_data, weights
//  N     8   input samples per vector (N >= M)
//  M     3   kernel taps (M >= 1)
//  RELU  0   1: negative results forced to 0 before saturation
// PORTS
//  clk      in   1  single clock, all flops on posedge
//  reset    in   1  asynchronous, active-low; one clock; reset is asynchronous and active-low
//  x_data   in   T  signed input word (weights first, then samples)
//  x_valid  in   1  x_data valid
//  x_ready  out  1  block accepts x_data this cycle
//  y_data   out  T  signed saturated result
//  y_valid  out  1  y_data valid
//  y_ready  in   1  downstream accepts y_data this cycle
// BEHAVIOUR
//  - Transfer on either port occurs only on a posedge with valid && ready both high.
//  - Reset (reset==0, async): state=S_IDLE, all counters 0, acc 0, y_valid 0, y_data 0.
//    x_ready=0 throughout reset.
//  - States:
//    S_IDLE -> S_LOAD unconditionally on the first edge after reset release.
//    S_LOAD: x_ready=1; count i=0..M+N-1; i<M writes w[i], else x[i-M].
//            After the accept with i==M+N-1: go to S_MAC with k=0, m=0, acc=0.
//    S_MAC:  x_ready=0, y_valid=0; each cycle acc += w[m]*x[k+m], m++.
//            On the cycle with m==M-1: register y_data=sat(relu(acc+product)), go to S_OUT.
//    S_OUT:  y_valid=1; y_data held stable until the transfer.
//            On transfer: if k==N-M go to S_LOAD (next vector), else k++, m=0, acc=0, go to S_MAC.
//  - Latency: first y_valid is high exactly M cycles after the edge that accepts the last sample.
//    Each subsequent y_valid is high M cycles after the previous y transfer.
//  - Arithmetic:
//    product is 2T bits; acc is 2T+clog2(M)+1 bits signed; no intermediate overflow.
//    sat clamps to [-2^(T-1), 2^(T-1)-1].
//  - Rules:
//    x_data is ignored when x_ready==0.
//    y_valid, once high, stays high until the transfer (never withdrawn).
//    y_valid is never combinationally dependent on y_ready.
//  - x_valid toggling mid-vector only stalls loading; i does not advance without a transfer.
//  - Reset asserted in any state aborts the vector; no partial outputs after release.
//  - Weights are reloaded every vector; no weight persistence across vectors.
// TESTING (T=16, N=8, M=3 unless noted)
//  1. w={1,2,3}, x=1..8, rand x_valid/y_ready
//     -> y = 14,20,26,32,38,44 (6 outputs), then x_ready=1 again.
//  2. w={16384,16384,16384}, x all 32767 -> every y=0x7FFF.
//     w all 16384, x all -32768 -> every y=0x8000.
//  3. w={-1,0,0}, x=1..8: RELU=0 -> y=-1..-6 (0xFFFF..0xFFFA); RELU=1 -> all y=0.
//  4. y_ready held 0 for 10 cycles during S_OUT -> y_valid stays 1, y_data unchanged,
//     x_ready stays 0, no lost or duplicated outputs.
//  5. reset pulled low after the 3rd y transfer of vector 1, then vector 1 resent
//     -> outputs restart at y[0]=14. The block never emits y[3] from the aborted pass.
//  6. Three back-to-back vectors with x_valid held 1 -> 18 outputs match the model.
//     x_ready=0 in every S_MAC/S_OUT cycle.

Source files
------------

// File: rtl/conv1d_stream_layer.sv
// Streaming 1-D convolution layer: loads M weights then N samples on x, and emits
// the N-M+1 saturated (optionally ReLU'd) dot products on y, one per valid/ready transfer.
module conv1d_stream_layer #(
  parameter int unsigned T    = 16,
  parameter int unsigned N    = 8,
  parameter int unsigned M    = 3,
  parameter bit          RELU = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);

  localparam int unsigned IW = $clog2(M + N);
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned PW = 2 * T;
  localparam int unsigned AW = 2 * T + $clog2(M) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_MAC  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic signed [AW-1:0] SAT_MAX = $signed({{(AW-T+1){1'b0}}, {(T-1){1'b1}}});
  localparam logic signed [AW-1:0] SAT_MIN = $signed({{(AW-T+1){1'b1}}, {(T-1){1'b0}}});

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [IW-1:0]        i_cnt;
  logic [KW-1:0]        k_cnt;
  logic [MW-1:0]        m_cnt;
  logic signed [AW-1:0] acc;
  logic signed [T-1:0]  w_mem [M];
  logic signed [T-1:0]  x_mem [N];

  logic                 x_take_c;
  logic                 y_take_c;
  logic                 load_last_c;
  logic                 mac_last_c;
  logic                 out_last_c;
  logic [KW-1:0]        x_idx_c;
  logic signed [PW-1:0] prod_c;
  logic signed [AW-1:0] sum_c;
  logic signed [AW-1:0] relu_c;
  logic signed [T-1:0]  sat_c;

  assign x_take_c    = x_valid && x_ready;
  assign y_take_c    = y_valid && y_ready;
  assign load_last_c = (i_cnt == IW'(M + N - 1));
  assign mac_last_c  = (m_cnt == MW'(M - 1));
  assign out_last_c  = (k_cnt == KW'(N - M));

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_LOAD;
      S_LOAD:  if (x_take_c && load_last_c) state_nxt = S_MAC;
      S_MAC:   if (mac_last_c) state_nxt = S_OUT;
      S_OUT:   if (y_take_c) state_nxt = out_last_c ? S_LOAD : S_MAC;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One tap per cycle: product, running sum, then ReLU and clamp for the final tap
  always_comb begin
    x_idx_c = k_cnt + KW'(m_cnt);
    prod_c  = w_mem[m_cnt] * x_mem[x_idx_c];
    sum_c   = acc + $signed({{(AW-PW){prod_c[PW-1]}}, prod_c});
    relu_c  = (RELU && sum_c[AW-1]) ? '0 : sum_c;
    if (relu_c > SAT_MAX) begin
      sat_c = T'(SAT_MAX);
    end else if (relu_c < SAT_MIN) begin
      sat_c = T'(SAT_MIN);
    end else begin
      sat_c = T'(relu_c);
    end
  end

  // State register; handshake flags registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      x_ready <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      x_ready <= (state_nxt == S_LOAD);
      y_valid <= (state_nxt == S_OUT);
    end
  end

  // Counters, accumulator and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_cnt  <= '0;
      k_cnt  <= '0;
      m_cnt  <= '0;
      acc    <= '0;
      y_data <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (x_take_c) begin
            if (load_last_c) begin
              i_cnt <= '0;
              k_cnt <= '0;
              m_cnt <= '0;
              acc   <= '0;
            end else begin
              i_cnt <= i_cnt + IW'(1);
            end
          end
        end
        S_MAC: begin
          if (mac_last_c) begin
            y_data <= sat_c;
            m_cnt  <= '0;
            acc    <= '0;
          end else begin
            acc   <= sum_c;
            m_cnt <= m_cnt + MW'(1);
          end
        end
        S_OUT: begin
          if (y_take_c && !out_last_c) k_cnt <= k_cnt + KW'(1);
        end
        default: ;
      endcase
    end
  end

  // Weight and sample storage, written in arrival order
  always_ff @(posedge clk) begin
    if (x_take_c) begin
      if (i_cnt < IW'(M)) begin
        w_mem[MW'(i_cnt)] <= x_data;
      end else begin
        x_mem[KW'(i_cnt - IW'(M))] <= x_data;
      end
    end
  end

endmodule

// File: tb/tb_conv1d_stream_layer.sv
// Bench for conv1d_stream_layer: two instances (RELU=0 and RELU=1) driven in lockstep,
// outputs compared against a plain-arithmetic convolution model.
module tb_conv1d_stream_layer;

  localparam int T = 16;
  localparam int N = 8;
  localparam int M = 3;
  localparam longint YMAX = (longint'(1) <<< (T - 1)) - 1;
  localparam longint YMIN = -(longint'(1) <<< (T - 1));

  logic                clk = 1'b0;
  logic                reset;
  logic signed [T-1:0] x_data;
  logic                x_valid;
  logic                y_ready;
  logic                x_ready, x_ready_r;
  logic                y_valid, y_valid_r;
  logic signed [T-1:0] y_data, y_data_r;

  int total = 0;
  int bad   = 0;

  logic signed [T-1:0] wv [M];
  logic signed [T-1:0] xv [N];

  always #5 clk = ~clk;

  conv1d_stream_layer #(.T(T), .N(N), .M(M), .RELU(1'b0)) dut (
    .clk(clk), .reset(reset), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  conv1d_stream_layer #(.T(T), .N(N), .M(M), .RELU(1'b1)) dut_r (
    .clk(clk), .reset(reset), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_r),
    .y_data(y_data_r), .y_valid(y_valid_r), .y_ready(y_ready)
  );

  // Reference: full-precision dot product, optional ReLU, clamp to T bits
  function automatic logic signed [T-1:0] ref_y(input int k, input bit relu);
    longint s = 0;
    for (int j = 0; j < M; j++) s += longint'(wv[j]) * longint'(xv[k + j]);
    if (relu && s < 0) s = 0;
    if (s > YMAX) s = YMAX;
    if (s < YMIN) s = YMIN;
    return T'(s);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Push one vector and collect its outputs; abort_after>=0 returns once that many outputs moved
  task automatic run_vector(input int abort_after, input int stall_k, input int stall_len,
                            input bit rnd);
    int  cyc;
    int  lat;
    int  hold;
    bit  took;
    logic signed [T-1:0] e0, e1;
    for (int i = 0; i < M + N; i++) begin
      if (i < M) x_data = wv[i];
      else       x_data = xv[i - M];
      cyc = 0;
      forever begin
        x_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        took = x_valid && x_ready;
        tick();
        if (took) break;
        cyc++;
        if (cyc > 100) begin
          total++; bad++;
          $display("FAIL load_timeout word=%0d x_ready=%b required=1", i, x_ready);
          x_valid = 1'b0;
          return;
        end
      end
    end
    for (int k = 0; k <= N - M; k++) begin
      if (k == abort_after) return;
      lat = 0;
      while (y_valid !== 1'b1 && lat < 50) begin
        total++;
        if (x_ready !== 1'b0 || x_ready_r !== 1'b0) begin
          bad++;
          $display("FAIL x_ready_in_mac k=%0d got=%b/%b required=0", k, x_ready, x_ready_r);
        end
        x_data  = T'($urandom);
        x_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        lat++;
      end
      total++;
      if (lat !== M) begin
        bad++;
        $display("FAIL y_latency k=%0d got=%0d required=%0d", k, lat, M);
        if (lat >= 50) return;
      end
      e0 = ref_y(k, 1'b0);
      e1 = ref_y(k, 1'b1);
      hold = (k == stall_k) ? stall_len : (rnd ? $urandom_range(0, 3) : 0);
      for (int h = 0; h < hold; h++) begin
        y_ready = 1'b0;
        x_data  = T'($urandom);
        tick();
        total++;
        if (y_valid !== 1'b1 || y_data !== e0 || x_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold k=%0d cyc=%0d got v=%b d=%0d xr=%b required v=1 d=%0d xr=0",
                   k, h, y_valid, y_data, x_ready, e0);
        end
      end
      total++;
      if (y_data !== e0) begin
        bad++;
        $display("FAIL y_data k=%0d got=%0d required=%0d", k, y_data, e0);
      end
      total++;
      if (y_valid_r !== 1'b1 || y_data_r !== e1) begin
        bad++;
        $display("FAIL y_data_relu k=%0d got v=%b d=%0d required v=1 d=%0d",
                 k, y_valid_r, y_data_r, e1);
      end
      y_ready = 1'b1;
      tick();
      y_ready = 1'b0;
    end
    total++;
    if (x_ready !== 1'b1 || y_valid !== 1'b0) begin
      bad++;
      $display("FAIL vector_end got xr=%b yv=%b required xr=1 yv=0", x_ready, y_valid);
    end
    x_valid = 1'b0;
  endtask

  task automatic set_ramp_x;
    for (int i = 0; i < N; i++) xv[i] = T'(i + 1);
  endtask

  task automatic test_reset;
    reset = 1'b0; x_valid = 1'b0; y_ready = 1'b0; x_data = '0;
    repeat (3) tick();
    total++;
    if (x_ready !== 1'b0 || y_valid !== 1'b0 || y_data !== '0 || y_data_r !== '0) begin
      bad++;
      $display("FAIL reset_state got xr=%b yv=%b yd=%0d required 0/0/0", x_ready, y_valid, y_data);
    end
    reset = 1'b1;
    #1;
    total++;
    if (x_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_x_ready got=%b required=0", x_ready);
    end
    tick();
    total++;
    if (x_ready !== 1'b1 || x_ready_r !== 1'b1) begin
      bad++;
      $display("FAIL load_x_ready got=%b/%b required=1", x_ready, x_ready_r);
    end
  endtask

  task automatic test_basic;
    wv[0] = 16'sd1; wv[1] = 16'sd2; wv[2] = 16'sd3;
    set_ramp_x();
    run_vector(-1, -1, 0, 1'b1);
  endtask

  task automatic test_saturation;
    for (int j = 0; j < M; j++) wv[j] = 16'sd16384;
    for (int i = 0; i < N; i++) xv[i] = 16'sd32767;
    run_vector(-1, -1, 0, 1'b1);
    for (int i = 0; i < N; i++) xv[i] = -16'sd32768;
    run_vector(-1, -1, 0, 1'b1);
  endtask

  task automatic test_relu;
    wv[0] = -16'sd1; wv[1] = 16'sd0; wv[2] = 16'sd0;
    set_ramp_x();
    run_vector(-1, -1, 0, 1'b1);
  endtask

  task automatic test_stall;
    wv[0] = 16'sd1; wv[1] = 16'sd2; wv[2] = 16'sd3;
    set_ramp_x();
    run_vector(-1, 2, 10, 1'b0);
  endtask

  task automatic test_abort;
    wv[0] = 16'sd1; wv[1] = 16'sd2; wv[2] = 16'sd3;
    set_ramp_x();
    run_vector(3, -1, 0, 1'b1);
    x_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (y_valid !== 1'b0 || x_ready !== 1'b0 || y_data !== '0) begin
      bad++;
      $display("FAIL abort_reset got yv=%b xr=%b yd=%0d required 0/0/0", y_valid, x_ready, y_data);
    end
    repeat (2) tick();
    reset = 1'b1;
    repeat (6) begin
      tick();
      total++;
      if (y_valid !== 1'b0 || y_valid_r !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_output got yv=%b/%b required=0", y_valid, y_valid_r);
      end
    end
    run_vector(-1, -1, 0, 1'b1);
  endtask

  task automatic test_back_to_back;
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < M; j++) wv[j] = T'($urandom_range(0, 400)) - 16'sd200;
      for (int i = 0; i < N; i++) xv[i] = T'($urandom);
      run_vector(-1, -1, 0, 1'b0);
    end
  endtask

  task automatic test_random;
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < M; j++) wv[j] = T'($urandom);
      for (int i = 0; i < N; i++) xv[i] = T'($urandom_range(0, 2000)) - 16'sd1000;
      run_vector(-1, $urandom_range(0, N - M), $urandom_range(1, 6), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_relu();
    test_stall();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
